// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Four-digit time-multiplexed 7-segment display driver. Four BCD digits are
// captured into a shadow register by a LOAD strobe and scanned one digit at a
// time onto a shared segment bus. Each digit slot opens with a short blanking
// interval (all commons off) to prevent ghosting, followed by the drive
// interval. Leading zeros can optionally be blanked.
//
// Ports:
//   CLK_50MHz  in   1   system clock, all state changes on its rising edge
//   Res        in   1   synchronous reset, active-high
//   DIGITS     in   16  four BCD nibbles, DIGITS[4i+3:4i] = digit i (0 = rightmost)
//   LOAD       in   1   single-cycle strobe capturing DIGITS and LZ_BLANK
//   LZ_BLANK   in   1   leading-zero blanking enable, captured with LOAD
//   SEG        out  7   segments gfedcba, active-low (0 = lit)
//   SEG_COM    out  4   one-hot digit select, active-high, bit i = digit i
//   FRAME      out  1   one-cycle pulse on the last cycle of the digit-3 slot
//
// Parameters:
//   CLK_HZ     input clock frequency
//   SCAN_HZ    per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ cycles per slot
//   BLANK_CYC  blanking cycles at the start of each slot, 1 <= BLANK_CYC < DIV
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 64
) (
  input  logic        CLK_50MHz,
  input  logic        Res,
  input  logic [15:0] DIGITS,
  input  logic        LOAD,
  input  logic        LZ_BLANK,
  output logic [6:0]  SEG,
  output logic [3:0]  SEG_COM,
  output logic        FRAME
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  localparam logic [6:0] SEG_OFF = 7'b111_1111;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_t;

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] slot_cnt_next;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic             snapshot_en;

  logic [15:0]      shadow_digits;
  logic             shadow_lz;

  logic [3:0]       cur_nibble;
  logic             cur_blank;
  logic [3:0]       drive_nibble;
  logic             drive_blank;

  logic [6:0]       seg_next;
  logic [3:0]       seg_com_next;
  logic             frame_next;

  // Active-low gfedcba glyphs; anything outside 0-9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'd0:    glyph = 7'b100_0000;
      4'd1:    glyph = 7'b111_1001;
      4'd2:    glyph = 7'b010_0100;
      4'd3:    glyph = 7'b011_0000;
      4'd4:    glyph = 7'b001_1001;
      4'd5:    glyph = 7'b001_0010;
      4'd6:    glyph = 7'b000_0010;
      4'd7:    glyph = 7'b101_1000;
      4'd8:    glyph = 7'b000_0000;
      4'd9:    glyph = 7'b001_1000;
      default: glyph = 7'b011_1111;
    endcase
    return glyph;
  endfunction

  // Shadow register: the digits and blanking mode the scanner reads from.
  // The last LOAD wins; reset clears it back to all zeros.
  always_ff @(posedge CLK_50MHz) begin
    if (Res) begin
      shadow_digits <= 16'h0000;
      shadow_lz     <= 1'b0;
    end else if (LOAD) begin
      shadow_digits <= DIGITS;
      shadow_lz     <= LZ_BLANK;
    end
  end

  // Scan state register: phase within the slot, slot counter and the digit
  // index. Reset drops straight back to the start of digit 0's blank phase.
  always_ff @(posedge CLK_50MHz) begin
    if (Res) begin
      state    <= ST_BLANK;
      slot_cnt <= '0;
      idx      <= 2'd0;
    end else begin
      state    <= state_next;
      slot_cnt <= slot_cnt_next;
      idx      <= idx_next;
    end
  end

  // Next-state logic. The counter free-runs over 0..DIV-1 so every slot is
  // exactly DIV cycles long; the phase only decides what is shown. The
  // BLANK->DRIVE transition is also the moment the digit for this slot is
  // snapshotted, and the DRIVE->BLANK transition steps to the next digit.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    snapshot_en   = 1'b0;
    slot_cnt_next = (slot_cnt == CNT_LAST) ? '0 : slot_cnt + 1'b1;
    case (state)
      ST_BLANK: begin
        if (slot_cnt == BLANK_LAST) begin
          state_next  = ST_DRIVE;
          snapshot_en = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (slot_cnt == CNT_LAST) begin
          state_next = ST_BLANK;
          idx_next   = idx + 2'd1;
        end
      end
      default: begin
        state_next = ST_BLANK;
      end
    endcase
  end

  // Selects the current digit out of the shadow register and decides whether
  // it is a leading zero: digit i (i >= 1) is dark when it and every digit
  // above it are zero. Digit 0 is always shown so "0" is never fully blank.
  always_comb begin
    cur_nibble = shadow_digits[{idx, 2'b00} +: 4];
    cur_blank  = 1'b0;
    case (idx)
      2'd1:    cur_blank = shadow_lz && (shadow_digits[15:4]  == 12'h000);
      2'd2:    cur_blank = shadow_lz && (shadow_digits[15:8]  == 8'h00);
      2'd3:    cur_blank = shadow_lz && (shadow_digits[15:12] == 4'h0);
      default: cur_blank = 1'b0;
    endcase
  end

  // Drive register: frozen for the whole drive phase so a LOAD arriving
  // mid-slot cannot change what the current digit shows; it shows up in the
  // next slot instead.
  always_ff @(posedge CLK_50MHz) begin
    if (Res) begin
      drive_nibble <= 4'h0;
      drive_blank  <= 1'b0;
    end else if (snapshot_en) begin
      drive_nibble <= cur_nibble;
      drive_blank  <= cur_blank;
    end
  end

  // Output decode from the current phase. A blanked leading zero keeps its
  // common asserted with all segments off, so scan timing is unchanged.
  always_comb begin
    seg_next     = SEG_OFF;
    seg_com_next = 4'b0000;
    frame_next   = (idx == 2'd3) && (slot_cnt == CNT_LAST);
    if (state == ST_DRIVE) begin
      seg_com_next = 4'b0001 << idx;
      seg_next     = drive_blank ? SEG_OFF : seg_decode(drive_nibble);
    end
  end

  // Output registers, so nothing at the pins is combinational from inputs.
  always_ff @(posedge CLK_50MHz) begin
    if (Res) begin
      SEG     <= SEG_OFF;
      SEG_COM <= 4'b0000;
      FRAME   <= 1'b0;
    end else begin
      SEG     <= seg_next;
      SEG_COM <= seg_com_next;
      FRAME   <= frame_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench for seg7_scan_driver with a small configuration
// (DIV=16, BLANK_CYC=4). A behavioural model tracks the cycle number since
// reset release and derives slot/phase/digit with plain arithmetic; a compare
// process checks every output on every cycle, and directed scenarios pin the
// model with hand-computed literal values before a randomized run.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int CLK_HZ    = 16000;
  localparam int SCAN_HZ   = 1000;
  localparam int BLANK_CYC = 4;
  localparam int DIV       = CLK_HZ / SCAN_HZ;

  logic        clk;
  logic        res;
  logic [15:0] digits;
  logic        load;
  logic        lz;
  logic [6:0]  seg;
  logic [3:0]  seg_com;
  logic        frame;

  int errors;
  int checks;

  // Model state
  int          cyc;
  int          pos;
  int          slot;
  bit          model_valid;
  logic [15:0] m_shadow;
  logic        m_lz;
  logic [15:0] m_snap;
  logic        m_snap_lz;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_com;
  logic        exp_frame;
  logic [6:0]  glyph_table [16];

  seg7_scan_driver #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .CLK_50MHz(clk),
    .Res      (res),
    .DIGITS   (digits),
    .LOAD     (load),
    .LZ_BLANK (lz),
    .SEG      (seg),
    .SEG_COM  (seg_com),
    .FRAME    (frame)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph a digit must show in a given slot, from a snapshot of the shadow.
  function automatic logic [6:0] expected_glyph(input logic [15:0] snap,
                                                input logic snap_lz,
                                                input int s);
    logic [15:0] upper;
    upper = snap >> (4 * s);
    if (snap_lz && (s > 0) && (upper == 16'h0000))
      return 7'b111_1111;
    return glyph_table[upper[3:0]];
  endfunction

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0b, expected %0b",
               name, cyc - 1, got, want);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic l,
                                input logic [15:0] d, input logic z);
    res    = r;
    load   = l;
    digits = d;
    lz     = z;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle until the outputs for cycle c are on the pins.
  task automatic run_to(input int c);
    while (cyc <= c) apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  // Reference model, advanced on every rising edge. Cycle cyc is the cyc-th
  // edge after reset release; slot and position fall out of division. The
  // digit for a slot is the shadow as it stood just before the edge that
  // ends the blank phase, so a LOAD on that edge is applied after the snapshot.
  always @(posedge clk) begin
    if (res) begin
      m_shadow    = 16'h0000;
      m_lz        = 1'b0;
      cyc         = 0;
      exp_seg     = 7'b111_1111;
      exp_com     = 4'b0000;
      exp_frame   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      pos  = cyc % DIV;
      slot = (cyc / DIV) % 4;
      if (pos == BLANK_CYC - 1) begin
        m_snap    = m_shadow;
        m_snap_lz = m_lz;
      end
      if (pos >= BLANK_CYC) begin
        exp_com = 4'(1 << slot);
        exp_seg = expected_glyph(m_snap, m_snap_lz, slot);
      end else begin
        exp_com = 4'b0000;
        exp_seg = 7'b111_1111;
      end
      exp_frame = (slot == 3) && (pos == DIV - 1);
      if (load) begin
        m_shadow = digits;
        m_lz     = lz;
      end
      cyc++;
    end
  end

  // Compare process: outputs are checked against the model every cycle on
  // the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check_output("seg_model",   32'(seg),     32'(exp_seg));
      check_output("com_model",   32'(seg_com), 32'(exp_com));
      check_output("frame_model", 32'(frame),   32'(exp_frame));
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    logic [15:0] rnd_digits;
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    model_valid = 1'b0;
    glyph_table = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b101_1000,
                    7'b000_0000, 7'b001_1000, 7'b011_1111, 7'b011_1111,
                    7'b011_1111, 7'b011_1111, 7'b011_1111, 7'b011_1111};
    res    = 1'b1;
    load   = 1'b0;
    digits = 16'h0000;
    lz     = 1'b0;
    @(negedge clk);

    // Reset state
    apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    check_output("reset_seg",   32'(seg),     32'h7F);
    check_output("reset_com",   32'(seg_com), 32'h0);
    check_output("reset_frame", 32'(frame),   32'h0);

    // Plain scan with nothing loaded
    run_to(3);  check_output("s1_c3_com",  32'(seg_com), 32'b0000);
    run_to(4);  check_output("s1_c4_com",  32'(seg_com), 32'b0001);
                check_output("s1_c4_seg",  32'(seg),     32'b100_0000);
    run_to(15); check_output("s1_c15_com", 32'(seg_com), 32'b0001);
    run_to(16); check_output("s1_c16_com", 32'(seg_com), 32'b0000);
                check_output("s1_c16_seg", 32'(seg),     32'h7F);
    run_to(20); check_output("s1_c20_com", 32'(seg_com), 32'b0010);
    run_to(52); check_output("s1_c52_com", 32'(seg_com), 32'b1000);
                check_output("s1_c52_seg", 32'(seg),     32'b100_0000);
    run_to(62); check_output("s1_c62_frm", 32'(frame),   32'h0);
    run_to(63); check_output("s1_c63_frm", 32'(frame),   32'h1);

    // LOAD 1234 during cycle 2 after a fresh reset
    apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    run_to(1);
    apply_stimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    run_to(5);  check_output("s2_d0_seg", 32'(seg), 32'b001_1001);
    run_to(20); check_output("s2_d1_seg", 32'(seg), 32'b011_0000);
    run_to(36); check_output("s2_d2_seg", 32'(seg), 32'b010_0100);
    run_to(52); check_output("s2_d3_seg", 32'(seg), 32'b111_1001);

    // Leading-zero blanking of 0050
    run_to(65);
    apply_stimulus(1'b0, 1'b1, 16'h0050, 1'b1);
    run_to(68);  check_output("s3_d0_seg", 32'(seg),     32'b100_0000);
    run_to(84);  check_output("s3_d1_seg", 32'(seg),     32'b001_0010);
    run_to(100); check_output("s3_d2_com", 32'(seg_com), 32'b0100);
                 check_output("s3_d2_seg", 32'(seg),     32'h7F);
    run_to(116); check_output("s3_d3_com", 32'(seg_com), 32'b1000);
                 check_output("s3_d3_seg", 32'(seg),     32'h7F);

    // All zero with blanking, then a dash in digit 1
    run_to(129);
    apply_stimulus(1'b0, 1'b1, 16'h0000, 1'b1);
    run_to(132); check_output("s4_d0_seg", 32'(seg),     32'b100_0000);
    run_to(148); check_output("s4_d1_com", 32'(seg_com), 32'b0010);
                 check_output("s4_d1_seg", 32'(seg),     32'h7F);
    run_to(193);
    apply_stimulus(1'b0, 1'b1, 16'h00A0, 1'b1);
    run_to(196); check_output("s4_a_d0",   32'(seg),     32'b100_0000);
    run_to(212); check_output("s4_a_d1",   32'(seg),     32'b011_1111);
    run_to(228); check_output("s4_a_d2",   32'(seg),     32'h7F);

    // LOAD on the edge that starts digit 2's drive phase (cycle 291)
    run_to(290);
    apply_stimulus(1'b0, 1'b1, 16'h9999, 1'b0);
    run_to(292); check_output("s5_d2_com", 32'(seg_com), 32'b0100);
                 check_output("s5_d2_seg", 32'(seg),     32'h7F);
    run_to(303); check_output("s5_d2_end", 32'(seg),     32'h7F);
    run_to(308); check_output("s5_d3_seg", 32'(seg),     32'b001_1000);

    // Reset in the middle of digit 2's drive phase
    apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    run_to(1);
    apply_stimulus(1'b0, 1'b1, 16'h9999, 1'b0);
    run_to(39); check_output("s6_pre_seg", 32'(seg),     32'b001_1000);
                check_output("s6_pre_com", 32'(seg_com), 32'b0100);
    apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    check_output("s6_rst_com", 32'(seg_com), 32'b0000);
    check_output("s6_rst_seg", 32'(seg),     32'h7F);
    run_to(4);  check_output("s6_c4_seg",  32'(seg),   32'b100_0000);
    run_to(22); check_output("s6_old63",   32'(frame), 32'h0);
    run_to(63); check_output("s6_c63_frm", 32'(frame), 32'h1);

    // Randomized traffic: sparse loads, zero-heavy digits, rare resets
    repeat (3000) begin
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(1, 0) == 0)
          rnd_digits[4*n +: 4] = 4'h0;
        else
          rnd_digits[4*n +: 4] = 4'($urandom_range(15, 0));
      end
      apply_stimulus(($urandom_range(199, 0) == 0),
                     ($urandom_range(7, 0) == 0),
                     rnd_digits,
                     1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Four-digit time-multiplexed 7-segment display driver.
- Sits directly downstream of the 0-9 counter/decoder stage. It accepts four BCD digits through a load strobe and scans them onto the shared SEG bus with a one-hot SEG_COM digit select.
- Inserts a dead-time blanking interval between digits to prevent ghosting. Optionally blanks leading zeros.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- SCAN_HZ, 1000, per-digit dwell rate. DIV = CLK_HZ/SCAN_HZ clock cycles per digit slot.
- BLANK_CYC, 64, cycles at the start of each slot with all digits off. Constraint: 1 <= BLANK_CYC < DIV.

Ports:
- CLK_50MHz  in   1   system clock; all state updates on its rising edge.
- Res        in   1   synchronous reset, active-high.
- DIGITS     in   16  four BCD nibbles; DIGITS[4i+3:4i] = digit i; digit 0 is rightmost.
- LOAD       in   1   single-cycle strobe; captures DIGITS and LZ_BLANK into the shadow register.
- LZ_BLANK   in   1   leading-zero blanking enable; captured with LOAD.
- SEG        out  7   segments gfedcba, active-low (0 = lit).
- SEG_COM    out  4   digit select, one-hot, active-high; bit i = digit i.
- FRAME      out  1   one-cycle pulse on the last cycle of the digit-3 slot.

Behaviour:
- Reset (Res=1 at a rising edge) sets:
  - SEG=7'b111_1111, SEG_COM=4'b0000, FRAME=0
  - shadow digits=16'h0000, shadow LZ=0
  - idx=0, state=BLANK, slot counter=0
- Reset mid-operation aborts the current slot immediately on that edge. LOAD is ignored while Res=1.
- All outputs are registered. No combinational path from inputs to outputs.
- Slot counter runs 0..DIV-1 and wraps; every slot is exactly DIV cycles; a frame is 4*DIV cycles.
- FSM:
  - BLANK: active for counter 0..BLANK_CYC-1. SEG_COM=0000, SEG=7F.
  - DRIVE: active for counter BLANK_CYC..DIV-1. SEG_COM = 1<<idx, SEG = decode(drive nibble).
  - DRIVE→BLANK at counter DIV-1; idx advances 0→1→2→3→0 on that edge.
- Cycle numbering: cycle 0 is the first edge with Res=0. SEG_COM=0000 during cycles 0..BLANK_CYC-1 and 0001 during cycles BLANK_CYC..DIV-1. Digit 1's blank interval starts at cycle DIV.
- Snapshot rule:
  - On the BLANK→DRIVE edge, the nibble for idx and the blanking decision are computed from the shadow register as it stood before that edge. They are held in the drive register for the whole DRIVE phase.
  - A LOAD landing on the same edge is first visible in the next slot.
- LOAD: on any edge with LOAD=1 and Res=0, shadow <= {DIGITS, LZ_BLANK}. Back-to-back LOADs are allowed; the last one wins.
- Decode (gfedcba, active-low):
  - 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001
  - 5=001_0010, 6=000_0010, 7=101_1000, 8=000_0000, 9=001_1000
  - nibbles 10-15 show dash = 011_1111
- Leading-zero blanking, when shadow LZ=1:
  - Digit i (i=1..3) is blanked if its nibble and every higher nibble are 0.
  - A blanked digit has SEG=7F with SEG_COM still asserted, so timing is unchanged.
  - Digit 0 is never blanked. Nibbles 10-15 count as non-zero.
- FRAME=1 exactly on the cycle where idx=3 and counter=DIV-1, else 0.

Test Plan (sim params CLK_HZ=16000, SCAN_HZ=1000 → DIV=16, BLANK_CYC=4):
- Reset then release, no LOAD → SEG_COM sequence:
  - 0000 for cycles 0-3, 0001 for cycles 4-15, 0000 for cycles 16-19, 0010 for cycles 20-31, …, 1000 for cycles 52-63
  - SEG=100_0000 whenever SEG_COM≠0
  - FRAME high only at cycle 63.
- LOAD DIGITS=16'h1234, LZ_BLANK=0 during cycle 2 → SEG is 001_1001 while SEG_COM=0001, then 011_0000 (0010), 010_0100 (0100), 111_1001 (1000).
- LOAD DIGITS=16'h0050, LZ_BLANK=1 → digits 3 and 2 show SEG=7F with SEG_COM asserted; digit 1 shows 001_0010; digit 0 shows 100_0000.
- LOAD 16'h0000 with LZ=1 → only digit 0 is lit (100_0000). LOAD 16'h00A0 with LZ=1 → digit 1 shows dash 011_1111.
- LOAD 16'h9999 on the same edge as BLANK→DRIVE for digit 2 → digit 2 keeps its old value for that slot; new digits appear from digit 3 onward. No SEG change mid-DRIVE.
- Assert Res for 1 cycle at cycle 40 (digit 2 in DRIVE) → next cycle SEG_COM=0000, SEG=7F, shadow cleared. Timing restarts as in the first scenario; FRAME does not pulse at the old cycle 63.
